cam_alloc_ctrl: RTL and testbench
=================================

CAM_ALLOC_CTRL -- requirements
Module: cam_alloc_ctrl

Interface
REQ-001 SHALL have parameter KEY, default 15, meaning lookup key width.
REQ-002 SHALL have parameter DEPTH, default 64, meaning CAM entry count (>=2).
REQ-003 SHALL have parameter ADDR, default $clog2(DEPTH), meaning entry index width.
REQ-004 SHALL have ports: clk in 1, clock; reset in 1, reset, synchronous, active-high.
REQ-005 SHALL have ports: flush in 1, clear all entries; inv_valid in 1 / inv_ready out 1 / inv_idx in ADDR, invalidate one entry.
REQ-006 SHALL have ports: req_valid in 1 / req_ready out 1 / req_key in KEY / req_insert in 1, lookup with optional insert-on-miss.
REQ-007 SHALL have ports: resp_valid out 1 / resp_ready in 1 / resp_hit out 1 / resp_new out 1 / resp_evict out 1 / resp_multi out 1 / resp_idx out ADDR.
REQ-008 SHALL have ports: count out ADDR+1, valid entries; full out 1.
REQ-009 SHALL have CAM ports: cam_re out 1, cam_rd out KEY+1, cam_rm out KEY+1, cam_match in 1, cam_multi in 1, cam_raddr in ADDR.
REQ-010 SHALL have CAM ports: cam_we out 1, cam_wd out KEY+1, cam_wm out KEY+1, cam_waddr out ADDR; entry MSB is the valid flag, wm bit 1 = keep bit.

Function
REQ-011 SHALL implement states IDLE, LOOKUP, WRITE, INV, FLUSH, RESP.
REQ-012 In IDLE, priority flush > inv_valid > req_valid; req_ready and inv_ready high only in IDLE with no higher-priority request.
REQ-013 IDLE+flush SHALL go FLUSH; IDLE+inv handshake SHALL capture inv_idx, go INV; IDLE+req handshake SHALL capture key/insert, go LOOKUP.
REQ-014 LOOKUP SHALL drive cam_re=1, cam_rd={1,key}, cam_rm=0 for exactly one cycle.
REQ-015 LOOKUP with cam_match SHALL latch hit=1, idx=cam_raddr, multi=cam_multi, go RESP.
REQ-016 LOOKUP miss with insert=0 SHALL latch hit=0, new=0, go RESP; with insert=1 SHALL pick victim, go WRITE.
REQ-017 Victim SHALL be lowest-index entry with local valid bit 0; if full, rr_ptr with evict=1.
REQ-018 WRITE SHALL drive cam_we=1, cam_waddr=victim, cam_wd={1,key}, cam_wm=0 one cycle; set valid[victim]; latch new=1, idx=victim; go RESP.
REQ-019 rr_ptr SHALL increment only on eviction, wrapping DEPTH-1 -> 0.
REQ-020 INV SHALL drive cam_we=1, cam_waddr=idx, cam_wd=0, cam_wm={0,all 1s} one cycle; clear valid[idx]; go IDLE.
REQ-021 FLUSH SHALL write cam_wd=0, cam_wm=0 to entries 0..DEPTH-1, one per cycle (DEPTH cycles); then valid=0, count=0, rr_ptr=0, go IDLE.
REQ-022 RESP SHALL hold resp_valid and all resp_* stable until resp_ready; then go IDLE.
REQ-023 count SHALL +1 on insert into free entry, unchanged on eviction, -1 on INV of a valid entry, unchanged on INV of invalid entry.
REQ-024 full SHALL equal (count==DEPTH).
REQ-025 cam_re/cam_we SHALL be 0 and cam_* data 0 outside their driving states.
REQ-026 flush/inv/req asserted outside IDLE SHALL NOT be accepted (held by requester).

Reset
REQ-027 On reset, state=IDLE, valid=0, count=0, rr_ptr=0, all resp_* and cam_* outputs 0; reset in any state (incl. FLUSH) aborts the operation.
REQ-028 The external CAM SHALL share reset, so the reset state is all entries invalid.

Structure
REQ-029 State enum and entry-layout constants (valid-bit position) SHALL live in package cam_ctrl_pkg.
REQ-030 Free-entry search SHALL be sub-module cam_free_enc (DEPTH-bit valid vector -> lowest-zero index plus found flag).

Verification (KEY=8, DEPTH=4)
REQ-031 Key 0x11 insert after reset -> resp_hit=0, resp_new=1, resp_idx=0, count=1.
REQ-032 Insert 0x11,0x22,0x33,0x44, then lookup 0x33 -> resp_hit=1, resp_idx=2, full=1.
REQ-033 Full CAM, insert 0x55 then 0x66 -> idx=0 then idx=1, resp_evict=1 both, count=4.
REQ-034 inv_idx=1, then lookup old key at idx1 -> resp_hit=0; next insert -> idx=1, count restored.
REQ-035 flush with req_valid simultaneous -> FLUSH first (4 cycles cam_we), req_ready only afterwards, then lookup misses, count=0.
REQ-036 resp_ready low 5 cycles -> resp_valid and resp_idx stable; reset mid-FLUSH -> IDLE next cycle, outputs 0.

Source files
------------

// File: rtl/cam_ctrl_pkg.sv
// Shared definitions for the CAM allocation controller: FSM states and entry layout.
package cam_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_WRITE,
      S_INV,
      S_FLUSH,
      S_RESP
   } cam_state_e;

   // A CAM entry is {valid, key}; the valid flag sits just above the key bits.
   function automatic int valid_bit(input int key_w);
      return key_w;
   endfunction

endpackage

// File: rtl/cam_free_enc.sv
// Lowest-index free-entry finder: returns the first zero in the valid vector.
module cam_free_enc #(
   parameter int DEPTH = 64,
   parameter int ADDR  = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0] valid_i,
   output logic [ADDR-1:0]  idx_o,
   output logic             found_o
);

   always_comb begin
      idx_o   = '0;
      found_o = 1'b0;
      // Scan downward so the lowest free index wins.
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!valid_i[i]) begin
            idx_o   = ADDR'(i);
            found_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cam_alloc_ctrl.sv
// CAM lookup/allocate controller: lookup with insert-on-miss, invalidate, flush, round-robin eviction.
module cam_alloc_ctrl
   import cam_ctrl_pkg::*;
#(
   parameter int KEY   = 15,
   parameter int DEPTH = 64,
   parameter int ADDR  = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            inv_valid,
   output logic            inv_ready,
   input  logic [ADDR-1:0] inv_idx,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [KEY-1:0]  req_key,
   input  logic            req_insert,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic            resp_hit,
   output logic            resp_new,
   output logic            resp_evict,
   output logic            resp_multi,
   output logic [ADDR-1:0] resp_idx,
   output logic [ADDR:0]   count,
   output logic            full,
   output logic            cam_re,
   output logic [KEY:0]    cam_rd,
   output logic [KEY:0]    cam_rm,
   input  logic            cam_match,
   input  logic            cam_multi,
   input  logic [ADDR-1:0] cam_raddr,
   output logic            cam_we,
   output logic [KEY:0]    cam_wd,
   output logic [KEY:0]    cam_wm,
   output logic [ADDR-1:0] cam_waddr
);

   localparam int VB = valid_bit(KEY);

   cam_state_e       state_q, state_d;
   logic [KEY-1:0]   key_q, key_d;
   logic             ins_q, ins_d;
   logic [ADDR-1:0]  idx_q, idx_d;
   logic             hit_q, hit_d, new_q, new_d, evict_q, evict_d, multi_q, multi_d;
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [ADDR:0]    count_q, count_d;
   logic [ADDR-1:0]  rr_q, rr_d;
   logic [ADDR-1:0]  fcnt_q, fcnt_d;
   logic [ADDR-1:0]  free_idx;
   logic             free_found;

   cam_free_enc #(.DEPTH(DEPTH), .ADDR(ADDR)) u_free (
      .valid_i (valid_q),
      .idx_o   (free_idx),
      .found_o (free_found)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         key_q   <= '0;
         ins_q   <= 1'b0;
         idx_q   <= '0;
         hit_q   <= 1'b0;
         new_q   <= 1'b0;
         evict_q <= 1'b0;
         multi_q <= 1'b0;
         valid_q <= '0;
         count_q <= '0;
         rr_q    <= '0;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         ins_q   <= ins_d;
         idx_q   <= idx_d;
         hit_q   <= hit_d;
         new_q   <= new_d;
         evict_q <= evict_d;
         multi_q <= multi_d;
         valid_q <= valid_d;
         count_q <= count_d;
         rr_q    <= rr_d;
         fcnt_q  <= fcnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      key_d     = key_q;
      ins_d     = ins_q;
      idx_d     = idx_q;
      hit_d     = hit_q;
      new_d     = new_q;
      evict_d   = evict_q;
      multi_d   = multi_q;
      valid_d   = valid_q;
      count_d   = count_q;
      rr_d      = rr_q;
      fcnt_d    = fcnt_q;
      req_ready = 1'b0;
      inv_ready = 1'b0;
      cam_re    = 1'b0;
      cam_rd    = '0;
      cam_rm    = '0;
      cam_we    = 1'b0;
      cam_wd    = '0;
      cam_wm    = '0;
      cam_waddr = '0;
      case (state_q)
         S_IDLE: begin
            inv_ready = !flush;
            req_ready = !flush && !inv_valid;
            if (flush) begin
               fcnt_d  = '0;
               state_d = S_FLUSH;
            end else if (inv_valid) begin
               idx_d   = inv_idx;
               state_d = S_INV;
            end else if (req_valid) begin
               key_d   = req_key;
               ins_d   = req_insert;
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            cam_re             = 1'b1;
            cam_rd[VB]         = 1'b1;
            cam_rd[KEY-1:0]    = key_q;
            hit_d   = 1'b0;
            new_d   = 1'b0;
            evict_d = 1'b0;
            multi_d = 1'b0;
            if (cam_match) begin
               hit_d   = 1'b1;
               idx_d   = cam_raddr;
               multi_d = cam_multi;
               state_d = S_RESP;
            end else if (ins_q) begin
               // No free slot means the round-robin victim is overwritten.
               idx_d   = free_found ? free_idx : rr_q;
               evict_d = !free_found;
               state_d = S_WRITE;
            end else begin
               state_d = S_RESP;
            end
         end
         S_WRITE: begin
            cam_we          = 1'b1;
            cam_waddr       = idx_q;
            cam_wd[VB]      = 1'b1;
            cam_wd[KEY-1:0] = key_q;
            valid_d[idx_q]  = 1'b1;
            new_d           = 1'b1;
            if (evict_q) rr_d = (rr_q == ADDR'(DEPTH - 1)) ? '0 : rr_q + ADDR'(1);
            else         count_d = count_q + (ADDR+1)'(1);
            state_d = S_RESP;
         end
         S_INV: begin
            // Only the valid flag is cleared; key bits are masked as keep.
            cam_we          = 1'b1;
            cam_waddr       = idx_q;
            cam_wm[KEY-1:0] = '1;
            if (valid_q[idx_q]) count_d = count_q - (ADDR+1)'(1);
            valid_d[idx_q] = 1'b0;
            state_d = S_IDLE;
         end
         S_FLUSH: begin
            cam_we    = 1'b1;
            cam_waddr = fcnt_q;
            if (fcnt_q == ADDR'(DEPTH - 1)) begin
               valid_d = '0;
               count_d = '0;
               rr_d    = '0;
               state_d = S_IDLE;
            end else begin
               fcnt_d = fcnt_q + ADDR'(1);
            end
         end
         S_RESP: begin
            if (resp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign resp_valid = (state_q == S_RESP);
   assign resp_hit   = resp_valid & hit_q;
   assign resp_new   = resp_valid & new_q;
   assign resp_evict = resp_valid & evict_q;
   assign resp_multi = resp_valid & multi_q;
   assign resp_idx   = resp_valid ? idx_q : '0;
   assign count      = count_q;
   assign full       = (count_q == (ADDR+1)'(DEPTH));

endmodule

// File: tb/tb_cam_alloc_ctrl.sv
// Self-checking bench: behavioural CAM plus an allocation reference model, directed and random ops.
module tb_cam_alloc_ctrl;
   localparam int KEY = 8, DEPTH = 4, ADDR = 2;

   logic clk = 1'b0, reset = 1'b1;
   logic flush = 0, inv_valid = 0, inv_ready, req_valid = 0, req_ready, req_insert = 0;
   logic [ADDR-1:0] inv_idx = '0, resp_idx, cam_raddr, cam_waddr;
   logic [KEY-1:0] req_key = '0;
   logic resp_valid, resp_ready = 0, resp_hit, resp_new, resp_evict, resp_multi, full;
   logic [ADDR:0] count;
   logic cam_re, cam_match, cam_multi, cam_we;
   logic [KEY:0] cam_rd, cam_rm, cam_wd, cam_wm;

   cam_alloc_ctrl #(.KEY(KEY), .DEPTH(DEPTH), .ADDR(ADDR)) dut (
      .clk(clk), .reset(reset), .flush(flush), .inv_valid(inv_valid), .inv_ready(inv_ready),
      .inv_idx(inv_idx), .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
      .req_insert(req_insert), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_hit(resp_hit), .resp_new(resp_new), .resp_evict(resp_evict), .resp_multi(resp_multi),
      .resp_idx(resp_idx), .count(count), .full(full), .cam_re(cam_re), .cam_rd(cam_rd),
      .cam_rm(cam_rm), .cam_match(cam_match), .cam_multi(cam_multi), .cam_raddr(cam_raddr),
      .cam_we(cam_we), .cam_wd(cam_wd), .cam_wm(cam_wm), .cam_waddr(cam_waddr));

   always #5 clk = ~clk;

   // Behavioural ternary-free CAM: masked write, lowest-index match.
   logic [KEY:0] cmem [DEPTH];
   always @(posedge clk) begin
      if (reset) for (int i = 0; i < DEPTH; i++) cmem[i] <= '0;
      else if (cam_we) cmem[cam_waddr] <= (cmem[cam_waddr] & cam_wm) | (cam_wd & ~cam_wm);
   end
   always_comb begin
      cam_match = 1'b0;
      cam_multi = 1'b0;
      cam_raddr = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (cam_re && (((cmem[i] ^ cam_rd) & ~cam_rm) == '0)) begin
            if (cam_match) cam_multi = 1'b1;
            else begin cam_match = 1'b1; cam_raddr = ADDR'(i); end
         end
      end
   end

   int re_cnt = 0, we_cnt = 0;
   always @(negedge clk) begin
      if (cam_re) re_cnt++;
      if (cam_we) we_cnt++;
   end

   // Reference model of controller-visible contents.
   logic [KEY-1:0] mkey [DEPTH];
   bit mval [DEPTH];
   int mcnt = 0, mrr = 0;
   int n_chk = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) begin mval[i] = 0; mkey[i] = '0; end
      mcnt = 0;
      mrr  = 0;
   endtask

   task automatic do_req(input logic [KEY-1:0] k, input bit ins, input int hold);
      bit eh, en, ee, fnd;
      int ei, n, re0, we0;
      logic [ADDR-1:0] idx0;
      eh = 0; en = 0; ee = 0; ei = 0; fnd = 0;
      for (int i = 0; i < DEPTH; i++)
         if (!eh && mval[i] && mkey[i] == k) begin eh = 1; ei = i; end
      if (!eh && ins) begin
         for (int i = 0; i < DEPTH; i++) if (!fnd && !mval[i]) begin fnd = 1; ei = i; end
         if (!fnd) begin ei = mrr; ee = 1; mrr = (mrr + 1) % DEPTH; end
         else mcnt++;
         mkey[ei] = k; mval[ei] = 1; en = 1;
      end
      re0 = re_cnt; we0 = we_cnt;
      req_valid = 1; req_key = k; req_insert = ins;
      n = 0;
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      chk("req_ready_timeout", n < 50, 1);
      @(negedge clk);
      req_valid = 0;
      n = 0;
      while (!resp_valid && n < 20) begin @(negedge clk); n++; end
      chk("resp_timeout", n < 20, 1);
      chk("resp_hit", resp_hit, eh);
      chk("resp_new", resp_new, en);
      chk("resp_evict", resp_evict, ee);
      chk("resp_multi", resp_multi, 0);
      if (eh || en) chk("resp_idx", resp_idx, ei);
      chk("count", count, mcnt);
      chk("full", full, mcnt == DEPTH);
      chk("lookup_cycles", re_cnt - re0, 1);
      chk("write_cycles", we_cnt - we0, en);
      idx0 = resp_idx;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("resp_hold_valid", resp_valid, 1);
         chk("resp_hold_idx", resp_idx, idx0);
      end
      resp_ready = 1;
      @(negedge clk);
      resp_ready = 0;
      chk("resp_drop", resp_valid, 0);
   endtask

   task automatic do_inv(input int i);
      int n, we0;
      if (mval[i]) mcnt--;
      mval[i] = 0;
      we0 = we_cnt;
      inv_valid = 1; inv_idx = ADDR'(i);
      n = 0;
      while (!inv_ready && n < 50) begin @(negedge clk); n++; end
      chk("inv_ready_timeout", n < 50, 1);
      @(negedge clk);
      inv_valid = 0;
      @(negedge clk);
      chk("inv_count", count, mcnt);
      chk("inv_writes", we_cnt - we0, 1);
   endtask

   task automatic do_flush();
      int n, we0;
      model_clear();
      we0 = we_cnt;
      flush = 1;
      @(negedge clk);
      flush = 0;
      n = 0;
      while (!inv_ready && n < 20) begin @(negedge clk); n++; end
      chk("flush_cycles", n, DEPTH);
      chk("flush_writes", we_cnt - we0, DEPTH);
      chk("flush_count", count, 0);
   endtask

   initial begin
      int n, we0;
      model_clear();
      repeat (2) @(negedge clk);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_count", count, 0);
      chk("rst_cam_we", cam_we, 0);
      reset = 0;
      @(negedge clk);
      chk("idle_full", full, 0);
      chk("idle_cam_re", cam_re, 0);
      chk("idle_cam_rd", cam_rd, 0);

      do_req(8'h11, 1, 0);
      do_req(8'h22, 1, 0);
      do_req(8'h33, 1, 0);
      do_req(8'h44, 1, 0);
      do_req(8'h33, 0, 0);
      do_req(8'h55, 1, 0);
      do_req(8'h66, 1, 0);
      do_inv(1);
      do_req(8'h66, 0, 0);
      do_req(8'h77, 1, 0);
      do_req(8'h33, 0, 5);
      do_inv(1);
      do_inv(1);

      for (int t = 0; t < 80; t++) begin
         int r;
         r = $urandom_range(0, 19);
         if (r == 0) do_flush();
         else if (r < 5) do_inv($urandom_range(0, DEPTH - 1));
         else do_req(KEY'($urandom_range(1, 6)), $urandom_range(0, 3) != 0, $urandom_range(0, 2));
      end

      // Flush and request together: flush wins, request waits out all flush writes.
      model_clear();
      we0 = we_cnt;
      flush = 1; req_valid = 1; req_key = 8'h11; req_insert = 0;
      #1;
      chk("flush_prio_ready", req_ready, 0);
      @(negedge clk);
      flush = 0;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      chk("flush_req_wait", n, DEPTH);
      chk("flush_req_writes", we_cnt - we0, DEPTH);
      req_valid = 0;
      do_req(8'h11, 0, 0);

      do_req(8'h21, 1, 0);
      // Reset in the middle of a flush.
      flush = 1;
      @(negedge clk);
      flush = 0;
      @(negedge clk);
      chk("midflush_we", cam_we, 1);
      reset = 1;
      @(negedge clk);
      model_clear();
      chk("rst_flush_idle", inv_ready, 1);
      chk("rst_flush_we", cam_we, 0);
      chk("rst_flush_waddr", cam_waddr, 0);
      chk("rst_flush_count", count, 0);
      chk("rst_flush_resp", resp_valid, 0);
      reset = 0;
      @(negedge clk);
      do_req(8'h21, 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
